// File: rtl/lc3b_mem_if.sv
// LC-3b CPU memory port: request/write-data from the CPU, read data and
// completion pulse from the memory.
interface lc3b_mem_if;
    logic [15:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_byte_enable;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_resp;

    modport master (
        output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
        input  mem_rdata, mem_resp
    );

    modport slave (
        input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
        output mem_rdata, mem_resp
    );
endinterface

// File: rtl/lc3b_mem_responder.sv
// Single-port 16-bit memory for the LC-3b CPU with a fixed number of wait
// states before a one-cycle mem_resp pulse; byte-lane writes supported.
module lc3b_mem_responder #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned WAIT_STATES = 2
) (
    input logic        clk,
    input logic        reset_n,
    lc3b_mem_if.slave  mem
);
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESPOND} state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [ADDR_WIDTH-1:0]   lat_idx;
    logic [1:0]              lat_be;
    logic [DATA_W-1:0]       lat_wdata;
    logic                    lat_write;
    logic [DATA_W-1:0]       rdata_q;
    logic                    resp_q;
    logic [DATA_W-1:0]       ram [DEPTH];

    logic                    req_c;
    logic                    access_c;
    logic [ADDR_WIDTH-1:0]   acc_idx_c;
    logic [1:0]              acc_be_c;
    logic [DATA_W-1:0]       acc_wdata_c;
    logic                    acc_write_c;
    logic                    unused_addr_c;

    assign unused_addr_c = ^{mem.mem_address[15:ADDR_WIDTH+1], mem.mem_address[0]};

    // With zero wait states the access happens on the capture edge itself,
    // so the array path must take the live request instead of the latches.
    always_comb begin
        req_c       = mem.mem_read | mem.mem_write;
        access_c    = 1'b0;
        acc_idx_c   = lat_idx;
        acc_be_c    = lat_be;
        acc_wdata_c = lat_wdata;
        acc_write_c = lat_write;
        if (state == S_IDLE) begin
            access_c    = req_c && (WAIT_STATES == 0);
            acc_idx_c   = mem.mem_address[ADDR_WIDTH:1];
            acc_be_c    = mem.mem_byte_enable;
            acc_wdata_c = mem.mem_wdata;
            acc_write_c = mem.mem_write;
        end else if (state == S_WAIT) begin
            access_c    = (cnt == CNT_W'(1));
        end
    end

    // Array contents survive reset; reset only blocks a pending write.
    always_ff @(posedge clk) begin
        if (access_c && acc_write_c && reset_n) begin
            if (acc_be_c[1]) ram[acc_idx_c][15:8] <= acc_wdata_c[15:8];
            if (acc_be_c[0]) ram[acc_idx_c][7:0]  <= acc_wdata_c[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            lat_idx   <= '0;
            lat_be    <= '0;
            lat_wdata <= '0;
            lat_write <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= 1'b0;
        end else begin
            resp_q <= 1'b0;
            if (access_c) begin
                resp_q <= 1'b1;
                if (!acc_write_c) rdata_q <= ram[acc_idx_c];
            end
            case (state)
                S_IDLE: begin
                    if (req_c) begin
                        lat_idx   <= mem.mem_address[ADDR_WIDTH:1];
                        lat_be    <= mem.mem_byte_enable;
                        lat_wdata <= mem.mem_wdata;
                        lat_write <= mem.mem_write;
                        cnt       <= CNT_W'(WAIT_STATES);
                        state     <= (WAIT_STATES == 0) ? S_RESPOND : S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) state <= S_RESPOND;
                end
                S_RESPOND: state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase
        end
    end

    assign mem.mem_rdata = rdata_q;
    assign mem.mem_resp  = resp_q;
endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Directed bench for lc3b_mem_responder: one instance with 2 wait states,
// one with 0 wait states, sharing clock and reset.
module tb_lc3b_mem_responder;
    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    lc3b_mem_if a ();
    lc3b_mem_if b ();

    lc3b_mem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(2)) u_ws2 (
        .clk(clk), .reset_n(reset_n), .mem(a)
    );
    lc3b_mem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .reset_n(reset_n), .mem(b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Drives one request and holds it until mem_resp; lat = edges from the
    // first edge after driving up to the edge that raised mem_resp (0 = timeout).
    task automatic txn(input bit sel, input logic [15:0] addr, input bit rd, input bit wr,
                       input logic [1:0] be, input logic [15:0] wd,
                       output int lat, output logic [15:0] rdata);
        logic r;
        if (sel) begin
            b.mem_address = addr; b.mem_read = rd; b.mem_write = wr;
            b.mem_byte_enable = be; b.mem_wdata = wd;
        end else begin
            a.mem_address = addr; a.mem_read = rd; a.mem_write = wr;
            a.mem_byte_enable = be; a.mem_wdata = wd;
        end
        lat   = 0;
        rdata = 'x;
        for (int k = 0; k < 20 && lat == 0; k++) begin
            @(posedge clk); #1;
            r = sel ? b.mem_resp : a.mem_resp;
            if (r) begin
                lat   = k + 1;
                rdata = sel ? b.mem_rdata : a.mem_rdata;
            end
        end
        if (sel) begin b.mem_read = 1'b0; b.mem_write = 1'b0; end
        else     begin a.mem_read = 1'b0; a.mem_write = 1'b0; end
    endtask

    initial begin
        int          lat;
        int          seen;
        logic [15:0] rd;
        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        a.mem_address = '0; a.mem_read = 1'b0; a.mem_write = 1'b0;
        a.mem_byte_enable = '0; a.mem_wdata = '0;
        b.mem_address = '0; b.mem_read = 1'b0; b.mem_write = 1'b0;
        b.mem_byte_enable = '0; b.mem_wdata = '0;

        #1;
        chk("reset_resp", 16'(a.mem_resp), 16'h0);
        chk("reset_rdata", a.mem_rdata, 16'h0000);
        chk("reset_resp_ws0", 16'(b.mem_resp), 16'h0);
        #11 reset_n = 1'b1;
        @(posedge clk); #1;

        // Full-word write then read
        txn(0, 16'h0010, 0, 1, 2'b11, 16'h1234, lat, rd);
        chk("wr_full_lat", 16'(lat), 16'd3);
        @(posedge clk); #1;
        chk("wr_full_single_pulse", 16'(a.mem_resp), 16'h0);
        txn(0, 16'h0010, 1, 0, 2'b11, 16'h0000, lat, rd);
        chk("rd_full_lat", 16'(lat), 16'd3);
        chk("rd_full_data", rd, 16'h1234);

        // Asynchronous reset in the middle of the resp cycle
        #3 reset_n = 1'b0;
        #1;
        chk("async_reset_resp", 16'(a.mem_resp), 16'h0);
        chk("async_reset_rdata", a.mem_rdata, 16'h0000);
        #2 reset_n = 1'b1;
        @(posedge clk); #1;

        // Byte-lane writes
        txn(0, 16'h0010, 0, 1, 2'b10, 16'hAB00, lat, rd);
        chk("wr_hi_lat", 16'(lat), 16'd3);
        txn(0, 16'h0011, 0, 1, 2'b01, 16'h00CD, lat, rd);
        chk("wr_lo_lat", 16'(lat), 16'd4);
        txn(0, 16'h0010, 1, 0, 2'b00, 16'h0000, lat, rd);
        chk("rd_bytes_data", rd, 16'hABCD);
        txn(0, 16'h0010, 0, 1, 2'b00, 16'h9999, lat, rd);
        chk("wr_be00_lat", 16'(lat), 16'd4);
        txn(0, 16'h0010, 1, 0, 2'b11, 16'h0000, lat, rd);
        chk("rd_after_be00", rd, 16'hABCD);

        // Back-to-back reads, second issued in the cycle after mem_resp
        txn(0, 16'h0020, 0, 1, 2'b11, 16'h0F0F, lat, rd);
        @(posedge clk); #1;
        txn(0, 16'h0010, 1, 0, 2'b11, 16'h0000, lat, rd);
        chk("b2b_first_lat", 16'(lat), 16'd3);
        chk("b2b_first_data", rd, 16'hABCD);
        txn(0, 16'h0020, 1, 0, 2'b11, 16'h0000, lat, rd);
        chk("b2b_spacing", 16'(lat), 16'd4);
        chk("b2b_second_data", rd, 16'h0F0F);
        seen = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (a.mem_resp) seen++;
        end
        chk("b2b_no_extra_pulse", 16'(seen), 16'd0);

        // Reset during WAIT discards the pending write
        a.mem_address = 16'h0010; a.mem_write = 1'b1;
        a.mem_byte_enable = 2'b11; a.mem_wdata = 16'hFFFF;
        @(posedge clk); #1;
        a.mem_write = 1'b0;
        reset_n = 1'b0;
        #2 reset_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (a.mem_resp) seen++;
        end
        chk("reset_mid_no_resp", 16'(seen), 16'd0);
        txn(0, 16'h0010, 1, 0, 2'b11, 16'h0000, lat, rd);
        chk("reset_mid_array_kept", rd, 16'hABCD);

        // Read+write together acts as a write; 0x0210 aliases 0x0010
        txn(0, 16'h0210, 1, 1, 2'b11, 16'h5555, lat, rd);
        chk("rw_both_lat", 16'(lat), 16'd4);
        chk("rw_both_rdata_kept", rd, 16'hABCD);
        txn(0, 16'h0010, 1, 0, 2'b11, 16'h0000, lat, rd);
        chk("alias_read", rd, 16'h5555);

        // Zero wait states
        txn(1, 16'h0004, 0, 1, 2'b11, 16'h00AA, lat, rd);
        chk("ws0_wr_lat", 16'(lat), 16'd1);
        @(posedge clk); #1;
        chk("ws0_single_pulse", 16'(b.mem_resp), 16'h0);
        txn(1, 16'h0004, 1, 0, 2'b11, 16'h0000, lat, rd);
        chk("ws0_rd_lat", 16'(lat), 16'd1);
        chk("ws0_rd_data", rd, 16'h00AA);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lc3b_mem_responder.md
# lc3b_mem_responder

Synthesizable single-port memory responder for the LC-3b multicycle CPU. It answers the CPU control unit's `mem_read`/`mem_write`/`mem_byte_enable` requests with a one-cycle `mem_resp` pulse after a programmable number of wait states, and supports byte-granular writes. It sits on the CPU memory port in place of the behavioural test memory, so the control FSM's wait-for-`mem_resp` states are exercised against real, cycle-accurate latency.

## Interface
- `ADDR_WIDTH`, default 8: number of word-address bits. The array holds 2^ADDR_WIDTH 16-bit words.
- `WAIT_STATES`, default 2: number of wait cycles inserted between request capture and response. Legal range is 0..15.
- `clk` input, 1 bit: single clock; all state updates on its rising edge.
- `reset_n` input, 1 bit: reset, asynchronous, active-low.
- `mem_address` input, 16 bits: byte address from the CPU MAR.
- `mem_read` input, 1 bit: read request, held by the initiator until `mem_resp` is seen.
- `mem_write` input, 1 bit: write request, held by the initiator until `mem_resp` is seen.
- `mem_byte_enable` input, 2 bits: bit 1 enables the high byte [15:8]; bit 0 enables the low byte [7:0].
- `mem_wdata` input, 16 bits: write data from the CPU MDR.
- `mem_rdata` output, 16 bits: registered read data.
- `mem_resp` output, 1 bit: transaction-complete pulse, exactly one cycle wide.

## Operation
- **States:** IDLE, WAIT, RESPOND.
- **IDLE:**
  - If `mem_write` or `mem_read` is 1, latch the address, byte enable, write data and operation type.
  - Load the wait counter with WAIT_STATES.
  - Next state is WAIT if WAIT_STATES > 0, otherwise RESPOND.
- **WAIT:** decrement the counter each cycle. When the counter reaches 1, the next state is RESPOND.
- **Array access:** happens on the edge that enters RESPOND, using only latched values.
  - Write: update only the enabled bytes. `mem_rdata` is unchanged.
  - Read: `mem_rdata` gets the full 16-bit word. `mem_byte_enable` is ignored on reads.
- **RESPOND:** `mem_resp` = 1 for this cycle only. Next state is always IDLE.
- **Word index:** `mem_address[ADDR_WIDTH:1]`. Bit 0 is ignored (byte lanes are selected only by `mem_byte_enable`). Upper bits are ignored, so addresses alias modulo 2^(ADDR_WIDTH+1) bytes.
- **Simultaneous `mem_read` and `mem_write`:** treated as a write.
- **Write with byte enable 00:** the array is unchanged, but `mem_resp` still pulses.
- **Request dropped during WAIT:** this is a protocol violation. The transaction still completes from latched values and `mem_resp` still pulses.
- **Request held during RESPOND:** belongs to the current transaction and is not re-captured.
- **Back-to-back requests:** a request present in the cycle after RESPOND is a new transaction and is captured in IDLE. No dead cycle is required.
- **Reset:**
  - Asserting `reset_n` at any time forces IDLE, `mem_resp` = 0 and `mem_rdata` = 16'h0000.
  - A pending write is discarded and the array is not modified.
  - Array contents are not reset.

## Timing
- **Latency:** the request is sampled in IDLE at cycle 0, and `mem_resp` is high in cycle WAIT_STATES+1.
  - With WAIT_STATES = 0, `mem_resp` is high in cycle 1.
- **Read data:** `mem_rdata` is valid in the same cycle as `mem_resp` and holds until the next read completes. The initiator loads its MDR in the `mem_resp` cycle.
- **Throughput:** one transaction per WAIT_STATES+2 cycles when requests are issued back-to-back.
- **Combinational paths:** none from inputs to outputs. `mem_resp` and `mem_rdata` are both flop outputs.
- **Reset values:** state = IDLE, `mem_resp` = 0, `mem_rdata` = 0, wait counter = 0.

## Test plan
- **Reset:** assert `reset_n` = 0 mid-cycle → `mem_resp` = 0 and `mem_rdata` = 0x0000 immediately, without waiting for a clock edge.
- **Full-word write then read (WAIT_STATES = 2):**
  - Write 0x1234 to 0x0010 with byte enable 11, holding the request → `mem_resp` pulses in cycle 3 only.
  - Read 0x0010 → `mem_rdata` = 0x1234 in its `mem_resp` cycle.
- **Byte-lane writes:**
  - Write 0xAB00 to 0x0010 with byte enable 10, then 0x00CD to 0x0011 with byte enable 01.
  - Read 0x0010 → 0xABCD.
  - Write with byte enable 00 → `mem_resp` pulses and a subsequent read still returns 0xABCD.
- **Back-to-back requests:**
  - Read 0x0010, then assert a read of 0x0020 in the cycle after `mem_resp` → two distinct `mem_resp` pulses 4 cycles apart (WAIT_STATES + 2) and no extra pulse.
  - WAIT_STATES = 0 → `mem_resp` one cycle after capture.
- **Reset mid-transaction:** start a write of 0xFFFF to 0x0010, then pulse `reset_n` low during WAIT → no `mem_resp`, and a later read of 0x0010 returns 0xABCD.
- **Priority and aliasing (ADDR_WIDTH = 8):**
  - Assert read and write together, writing 0x5555 to 0x0210 → treated as a write and `mem_rdata` is unchanged.
  - Read 0x0010 → 0x5555.
